// File: rtl/wb_arbiter2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// wb_arbiter2 -- two-master, one-slave Wishbone arbiter.
//
// Shares one Wishbone slave between master 0 (CPU) and master 1 (debug loader
// or DMA). Ownership is held for the full cyc of the owning master. When both
// masters are waiting, the master that did not own the bus most recently wins.
// The slave-side request and the ack/read-data return are pure combinational
// muxes selected by the registered owner, so arbitration adds one cycle of
// latency and the data path adds none.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a watchdog counts stalled
// strobe cycles. When the count reaches timeout_cycles, the arbiter ends the
// beat itself for one cycle and pulses timeout. That cycle has s_cyc/s_stb
// forced low and an ack with zero data returned to the owner. Without the
// macro, timeout is tied low and no counter exists.
//
// Parameters:
//   addr_width      Wishbone address width
//   data_width      Wishbone data width (sel is data_width/8 bits)
//   timeout_cycles  watchdog limit, 1..65535 (used only with the macro)
//
// Ports:
//   clock, reset                 clock; asynchronous active-high reset
//   m0_* / m1_*  (in)            master requests: adr, datwr, we, stb, cyc, sel
//   m0_datrd/m1_datrd, m*_ack    read data and acknowledge back to each master
//   s_* (out)                    request muxed from the current owner
//   s_datrd, s_ack (in)          slave response
//   grant                        one-hot owner: 01 = M0, 10 = M1, 00 = none
//   timeout                      one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_arbiter2 #(
  parameter int addr_width     = 32,
  parameter int data_width     = 32,
  parameter int timeout_cycles = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  // master 0
  input  logic [addr_width-1:0]   m0_adr,
  input  logic [data_width-1:0]   m0_datwr,
  input  logic                    m0_we,
  input  logic                    m0_stb,
  input  logic                    m0_cyc,
  input  logic [data_width/8-1:0] m0_sel,
  output logic [data_width-1:0]   m0_datrd,
  output logic                    m0_ack,
  // master 1
  input  logic [addr_width-1:0]   m1_adr,
  input  logic [data_width-1:0]   m1_datwr,
  input  logic                    m1_we,
  input  logic                    m1_stb,
  input  logic                    m1_cyc,
  input  logic [data_width/8-1:0] m1_sel,
  output logic [data_width-1:0]   m1_datrd,
  output logic                    m1_ack,
  // slave
  output logic [addr_width-1:0]   s_adr,
  output logic [data_width-1:0]   s_datwr,
  output logic                    s_we,
  output logic                    s_stb,
  output logic                    s_cyc,
  output logic [data_width/8-1:0] s_sel,
  input  logic [data_width-1:0]   s_datrd,
  input  logic                    s_ack,
  // status
  output logic [1:0]              grant,
  output logic                    timeout
);

  if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
    $error("wb_arbiter2: timeout_cycles must be in 1..65535");
  end

  // Encodings are chosen so the owner register is the one-hot grant itself.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_M0   = 2'b01,
    OWN_M1   = 2'b10
  } owner_e;

  owner_e owner_q, owner_d;
  logic   last_q, last_d;   // 0 = M0 owned most recently, 1 = M1

  // Request fields from the owner before any watchdog override.
  logic mux_cyc, mux_stb;
  logic fire;

  // ---------------------------------------------------------------------------
  // Owner selection
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch instead of combinational logic.
    owner_d = owner_q;
    unique case (owner_q)
      OWN_NONE: begin
        if (m0_cyc && m1_cyc) owner_d = last_q ? OWN_M0 : OWN_M1;
        else if (m0_cyc)      owner_d = OWN_M0;
        else if (m1_cyc)      owner_d = OWN_M1;
      end
      // An owner dropping cyc can only hand over or go idle; it is never
      // re-granted in the same edge, which keeps the round-robin fair.
      OWN_M0: if (!m0_cyc) owner_d = m1_cyc ? OWN_M1 : OWN_NONE;
      OWN_M1: if (!m1_cyc) owner_d = m0_cyc ? OWN_M0 : OWN_NONE;
      default: owner_d = OWN_NONE;
    endcase

    last_d = last_q;
    if (owner_d != OWN_NONE) last_d = (owner_d == OWN_M1);
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, regardless of statement order.
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;    // M0 wins the first tie after reset
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign grant = owner_q;

  // ---------------------------------------------------------------------------
  // Request / response muxes
  // ---------------------------------------------------------------------------
  always_comb begin
    s_adr    = '0;
    s_datwr  = '0;
    s_we     = 1'b0;
    s_sel    = '0;
    mux_cyc  = 1'b0;
    mux_stb  = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_datrd = '0;
    m1_datrd = '0;
    unique case (owner_q)
      OWN_M0: begin
        s_adr    = m0_adr;
        s_datwr  = m0_datwr;
        s_we     = m0_we;
        s_sel    = m0_sel;
        mux_cyc  = m0_cyc;
        mux_stb  = m0_stb;
        m0_ack   = s_ack;
        m0_datrd = s_datrd;
      end
      OWN_M1: begin
        s_adr    = m1_adr;
        s_datwr  = m1_datwr;
        s_we     = m1_we;
        s_sel    = m1_sel;
        mux_cyc  = m1_cyc;
        mux_stb  = m1_stb;
        m1_ack   = s_ack;
        m1_datrd = s_datrd;
      end
      default: ;
    endcase

    s_cyc = mux_cyc;
    s_stb = mux_stb;
    // The watchdog beat: the slave is released and the owner sees an ack
    // carrying zero data, so a hung slave cannot lock the master forever.
    if (fire) begin
      s_cyc    = 1'b0;
      s_stb    = 1'b0;
      m0_ack   = (owner_q == OWN_M0);
      m1_ack   = (owner_q == OWN_M1);
      m0_datrd = '0;
      m1_datrd = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TimeoutLim = 16'(timeout_cycles);

  logic [15:0] wdog_q, wdog_d;

  assign fire = (wdog_q == TimeoutLim);

  always_comb begin
    wdog_d = wdog_q;
    if (fire || s_ack || (owner_d != owner_q)) wdog_d = '0;
    else if (mux_cyc && mux_stb)               wdog_d = wdog_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end

  assign timeout = fire;
`else
  assign fire    = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter2.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_wb_arbiter2 -- directed bench for wb_arbiter2.
// One table row per clock cycle: inputs are driven just after the falling
// edge and the combinational outputs are compared 1 ns later, so each row's
// expected grant is the owner registered at the preceding rising edge.
// Reset-in-flight and the watchdog are hand-written sequences after the table.
// -----------------------------------------------------------------------------
module tb_wb_arbiter2;

  localparam logic [31:0] M0_ADR  = 32'h0000_0010;
  localparam logic [31:0] M1_ADR  = 32'h0000_0020;
  localparam logic [31:0] M0_DAT  = 32'h1111_1111;
  localparam logic [31:0] M1_DAT  = 32'h2222_2222;
  localparam logic [31:0] RD_DAT  = 32'hA5A5_A5A5;
  localparam int          N_VEC   = 24;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] m0_adr, m0_datwr, m1_adr, m1_datwr;
  logic        m0_we, m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_datrd, m1_datrd;
  logic        m0_ack, m1_ack;
  logic [31:0] s_adr, s_datwr, s_datrd;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [3:0]  s_sel;
  logic [1:0]  grant;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wb_arbiter2 #(
    .addr_width    (32),
    .data_width    (32),
    .timeout_cycles(4)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m0_adr  (m0_adr),
    .m0_datwr(m0_datwr),
    .m0_we   (m0_we),
    .m0_stb  (m0_stb),
    .m0_cyc  (m0_cyc),
    .m0_sel  (m0_sel),
    .m0_datrd(m0_datrd),
    .m0_ack  (m0_ack),
    .m1_adr  (m1_adr),
    .m1_datwr(m1_datwr),
    .m1_we   (m1_we),
    .m1_stb  (m1_stb),
    .m1_cyc  (m1_cyc),
    .m1_sel  (m1_sel),
    .m1_datrd(m1_datrd),
    .m1_ack  (m1_ack),
    .s_adr   (s_adr),
    .s_datwr (s_datwr),
    .s_we    (s_we),
    .s_stb   (s_stb),
    .s_cyc   (s_cyc),
    .s_sel   (s_sel),
    .s_datrd (s_datrd),
    .s_ack   (s_ack),
    .grant   (grant),
    .timeout (timeout)
  );

  typedef struct {
    logic       m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack;
    logic [1:0] grant;
    logic       s_cyc, s_stb, m0_ack, m1_ack;
  } vec_t;

  vec_t vecs [N_VEC];

  function automatic vec_t mk(input logic a0c, a0s, a1c, a1s, ack,
                              input logic [1:0] g,
                              input logic sc, ss, k0, k1);
    vec_t v;
    v.m0_cyc = a0c; v.m0_stb = a0s; v.m1_cyc = a1c; v.m1_stb = a1s;
    v.s_ack  = ack; v.grant  = g;   v.s_cyc  = sc;  v.s_stb  = ss;
    v.m0_ack = k0;  v.m1_ack = k1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Full output comparison given the expected owner for this cycle.
  task automatic check_cycle(input string tag, input logic [1:0] g,
                             input logic sc, ss, k0, k1);
    logic [31:0] e_adr, e_dat, e_rd0, e_rd1;
    logic [3:0]  e_sel;
    logic        e_we;
    e_adr = (g == 2'b01) ? M0_ADR : (g == 2'b10) ? M1_ADR : 32'h0;
    e_dat = (g == 2'b01) ? M0_DAT : (g == 2'b10) ? M1_DAT : 32'h0;
    e_sel = (g == 2'b01) ? 4'h3   : (g == 2'b10) ? 4'hC   : 4'h0;
    e_we  = (g == 2'b10);
    e_rd0 = (g == 2'b01) ? RD_DAT : 32'h0;
    e_rd1 = (g == 2'b10) ? RD_DAT : 32'h0;
    check({tag, " grant"},    32'(grant),    32'(g));
    check({tag, " s_cyc"},    32'(s_cyc),    32'(sc));
    check({tag, " s_stb"},    32'(s_stb),    32'(ss));
    check({tag, " m0_ack"},   32'(m0_ack),   32'(k0));
    check({tag, " m1_ack"},   32'(m1_ack),   32'(k1));
    check({tag, " s_adr"},    s_adr,         e_adr);
    check({tag, " s_datwr"},  s_datwr,       e_dat);
    check({tag, " s_sel"},    32'(s_sel),    32'(e_sel));
    check({tag, " s_we"},     32'(s_we),     32'(e_we));
    check({tag, " m0_datrd"}, m0_datrd,      e_rd0);
    check({tag, " m1_datrd"}, m1_datrd,      e_rd1);
    check({tag, " timeout"},  32'(timeout),  32'h0);
  endtask

  task automatic drive(input logic a0c, a0s, a1c, a1s, ack);
    m0_cyc = a0c; m0_stb = a0s; m1_cyc = a1c; m1_stb = a1s; s_ack = ack;
  endtask

  initial begin
    int stb_seen, ack_seen, to_seen, stb_before_ack;
    logic [31:0] ack_datrd;
    logic        ack_timeout, ack_stb;

    //             m0c m0s m1c m1s ack  grant  scyc sstb a0 a1
    // Tie after reset, handover, then alternating round-robin.
    vecs[0]  = mk(1, 1, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0);
    vecs[2]  = mk(0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1);
    vecs[4]  = mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    vecs[5]  = mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0);
    vecs[6]  = mk(0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0);
    vecs[7]  = mk(1, 1, 1, 1, 1, 2'b10, 1, 1, 0, 1);
    vecs[8]  = mk(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    // Hold: M0 keeps cyc through three beats while M1 waits.
    vecs[9]  = mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0);
    vecs[10] = mk(1, 0, 1, 1, 0, 2'b01, 1, 0, 0, 0);
    vecs[11] = mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0);
    vecs[12] = mk(1, 1, 1, 1, 1, 2'b01, 1, 1, 1, 0);
    vecs[13] = mk(0, 0, 1, 1, 0, 2'b01, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0);
    // Single master read, ack two cycles after the grant.
    vecs[16] = mk(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vecs[17] = mk(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    vecs[18] = mk(1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0);
    vecs[19] = mk(1, 1, 0, 0, 0, 2'b01, 1, 1, 0, 0);
    vecs[20] = mk(1, 1, 0, 0, 1, 2'b01, 1, 1, 1, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0);
    // M1 alone, left owning with stb high for the reset sequence.
    vecs[22] = mk(0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 1, 1, 0, 2'b10, 1, 1, 0, 0);

    reset    = 1'b1;
    m0_adr   = M0_ADR; m0_datwr = M0_DAT; m0_we = 1'b0; m0_sel = 4'h3;
    m1_adr   = M1_ADR; m1_datwr = M1_DAT; m1_we = 1'b1; m1_sel = 4'hC;
    s_datrd  = RD_DAT;
    drive(0, 0, 0, 0, 0);

    @(negedge clock);
    #1;
    check_cycle("reset", 2'b00, 0, 0, 0, 0);
    reset = 1'b0;

    for (int i = 0; i < N_VEC; i++) begin
      @(negedge clock);
      drive(vecs[i].m0_cyc, vecs[i].m0_stb, vecs[i].m1_cyc, vecs[i].m1_stb,
            vecs[i].s_ack);
      #1;
      check_cycle($sformatf("vec%0d", i), vecs[i].grant, vecs[i].s_cyc,
                  vecs[i].s_stb, vecs[i].m0_ack, vecs[i].m1_ack);
    end

    // Reset in the middle of an M1 beat: everything drops without an edge.
    s_ack = 1'b1;
    #1;
    check("pre-reset m1_ack", 32'(m1_ack), 32'h1);
    reset = 1'b1;
    #1;
    check("async grant",  32'(grant),  32'h0);
    check("async s_cyc",  32'(s_cyc),  32'h0);
    check("async s_stb",  32'(s_stb),  32'h0);
    check("async m1_ack", 32'(m1_ack), 32'h0);
    check("async s_adr",  s_adr,       32'h0);

    @(negedge clock);
    reset = 1'b0;
    drive(1, 1, 1, 1, 0);
    #1;
    check("post-reset grant idle", 32'(grant), 32'h0);
    @(negedge clock);
    #1;
    check("post-reset tie grant", 32'(grant), 32'h1);
    check("post-reset tie s_adr", s_adr, M0_ADR);

    // Stalled slave: release the bus, then let M0 strobe with no ack.
    @(negedge clock);
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    #1;
    check("idle before stall", 32'(grant), 32'h0);

    stb_seen = 0; ack_seen = 0; to_seen = 0; stb_before_ack = -1;
    ack_datrd = 32'hFFFF_FFFF; ack_timeout = 1'b0; ack_stb = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      drive(1, 1, 0, 0, 0);
      #1;
      if (m0_ack && ack_seen == 0) begin
        stb_before_ack = stb_seen;
        ack_datrd      = m0_datrd;
        ack_timeout    = timeout;
        ack_stb        = s_stb;
      end
      if (s_stb)   stb_seen++;
      if (m0_ack)  ack_seen++;
      if (timeout) to_seen++;
    end
`ifdef WB_ARB_TIMEOUT_EN
    check("wdog stb cycles before ack", 32'(stb_before_ack), 32'd4);
    check("wdog ack datrd",             ack_datrd,            32'h0);
    check("wdog timeout with ack",      32'(ack_timeout),     32'h1);
    check("wdog s_stb forced low",      32'(ack_stb),         32'h0);
    check("wdog pulse count",           32'(to_seen),         32'(ack_seen));
`else
    check("stall stb cycles", 32'(stb_seen), 32'd11);
    check("stall no ack",     32'(ack_seen), 32'd0);
    check("stall no timeout", 32'(to_seen),  32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hung run; nothing above waits on a DUT event, but the
  // bound keeps the bench terminating whatever happens.
  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master, one-slave Wishbone arbiter that shares the SoC bus between the `copperv_wb` CPU (master 0) and a second master such as a debug loader or DMA (master 1). It sits between the masters and the `wb2uart` slave. A grant is held for the whole `cyc` of the owning master, and the next grant is chosen round-robin. An optional watchdog terminates slave cycles that never acknowledge.

## Interface
Parameters:
- `addr_width`, default 32: Wishbone address width.
- `data_width`, default 32: Wishbone data width. `sel` width is `data_width/8`.
- `timeout_cycles`, default 255: watchdog limit in cycles. Range is 1..65535. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `m0_adr`/`m1_adr`  in  addr_width  master addresses.
- `m0_datwr`/`m1_datwr`  in  data_width  master write data.
- `m0_we`/`m1_we`, `m0_stb`/`m1_stb`, `m0_cyc`/`m1_cyc`  in  1  master controls.
- `m0_sel`/`m1_sel`  in  data_width/8  byte selects.
- `m0_datrd`/`m1_datrd`  out  data_width  read data.
- `m0_ack`/`m1_ack`  out  1  acknowledges.
- `s_adr`, `s_datwr`, `s_we`, `s_stb`, `s_cyc`, `s_sel`  out  as above  slave-side request.
- `s_datrd`  in  data_width  slave read data.
- `s_ack`  in  1  slave acknowledge.
- `grant`  out  2  one-hot owner: `01` = M0, `10` = M1, `00` = none.
- `timeout`  out  1  one-cycle pulse when the watchdog fires. Tied 0 without the macro.

## Operation
- Owner register has three values: NONE, M0, M1. A separate `last` bit records the most recent owner.
- Transitions from NONE:
  - Only `m0_cyc` high: go to M0.
  - Only `m1_cyc` high: go to M1.
  - Both high: grant the master that is not `last`.
  - Neither high: stay in NONE.
- Transitions from Mx:
  - Stay in Mx while `mx_cyc` is high.
  - When `mx_cyc` is low: go to the other master if its `cyc` is high, else go to NONE.
  - Mx cannot be re-granted in the cycle it drops `cyc`.
- `last` updates on every entry into M0 or M1.
- Slave-side request is a combinational mux of the owner's signals. When the owner is NONE, all `s_*` outputs are 0.
- `mx_ack = s_ack & (owner==Mx)`. `mx_datrd = s_datrd` when `owner==Mx`, else 0.
- A non-owner with `cyc` high waits. It sees no ack, and its signals never reach the slave.
- Data, address and `sel` are passed through with no width conversion.

## Timing
- Reset values (asynchronous): owner = NONE, `last` = M1 (so M0 wins the first tie), `grant` = `00`, `timeout` = 0, watchdog counter = 0. All `s_*` outputs and both acks are 0.
- Arbitration latency is one cycle: `cyc` sampled high at edge N means the request appears on the slave after edge N, i.e. in cycle N+1.
- Handover with the other master waiting: owner's `cyc` is low at edge N, and the new owner is driving the slave in cycle N+1 with no idle cycle.
- The request/ack path through the arbiter is zero-latency combinational.
- If `reset` asserts mid-cycle, the grant drops immediately. Masters must restart their transfers.

## Configuration
- Macro: `WB_ARB_TIMEOUT_EN`.
- When defined:
  - A 16-bit counter increments each cycle with `s_cyc & s_stb & ~s_ack`.
  - The counter clears on `s_ack`, on any owner change, and on reset.
  - When the counter equals `timeout_cycles`, the arbiter does the following for one cycle:
    - forces `s_cyc` and `s_stb` to 0;
    - drives the owner's ack to 1 with `datrd` = 0;
    - pulses `timeout` to 1.
  - The counter then clears. Ownership rules are unchanged.
- When undefined: no counter is built, `timeout` is constant 0, and a stalled slave hangs the owner indefinitely.

## Test plan
- Single master: M0 reads `0x10` and the slave acks after 2 cycles with `0xA5A5A5A5` -> `grant` = `01` one cycle after `cyc`; `m0_datrd` = `0xA5A5A5A5` with `m0_ack`; `m1_ack` stays 0.
- Tie after reset: both `cyc` rise in the same cycle -> M0 granted first. After M0 drops `cyc`, M1 is granted on the next edge with no NONE cycle.
- Round-robin: M0 and M1 request continuously with 1-cycle bursts -> `grant` alternates `01`, `10`, `01`, `10`.
- Hold: M0 keeps `cyc` high through 3 stb/ack beats while M1 requests -> `grant` stays `01` for all beats; no M1 signals appear on `s_*`.
- Reset mid-transfer: assert `reset` while M1 owns with `s_stb` = 1 -> `grant` and `s_cyc` go to 0 without waiting for a clock edge. After release, a tie grants M0.
- Watchdog (`WB_ARB_TIMEOUT_EN`, `timeout_cycles` = 4): slave never acks -> exactly 4 cycles of `s_stb` high, then a 1-cycle `m0_ack` with `m0_datrd` = 0 and `timeout` = 1.
